// File: rtl/synth_sched_pkg.sv
// Shared types for the pitch slot scheduler: FSM states, slot fields, key events.
package synth_sched_pkg;

  localparam int SCHED_V_WIDTH  = 3;
  localparam int SCHED_O_WIDTH  = 2;
  localparam int SCHED_OE_WIDTH = 1;

  localparam logic [7:0] KEY_SILENT = 8'hff;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SLOT,
    ST_GAP_SETUP,
    ST_GAP_STROBE,
    ST_GAP_HOLD
  } sched_state_t;

  typedef struct packed {
    logic [SCHED_V_WIDTH-1:0]  voice;
    logic [SCHED_O_WIDTH-1:0]  osc;
    logic [SCHED_OE_WIDTH-1:0] sub;
  } slot_t;

  typedef struct packed {
    logic [SCHED_V_WIDTH-1:0] voice;
    logic [7:0]               val;
  } key_evt_t;

endpackage

// File: rtl/key_event_fifo.sv
// Key event FIFO, entries split into a match tag (top TAG_W bits) and a value.
// Head visible combinationally; full blocks pushes; PITCH_SCHED_COALESCE_EN merges same-tag pushes.
module key_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 11,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_vld,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_dat
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int VW = WIDTH - TAG_W;

  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [VW-1:0]    val_q [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop, alloc, hit;
  logic [AW-1:0]    hit_idx;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push_vld && !full;
  assign do_pop   = pop_vld && !empty;
  assign head_dat = {tag_q[rd_ptr], val_q[rd_ptr]};

`ifdef PITCH_SCHED_COALESCE_EN
  // An entry leaving this cycle cannot absorb the push; it becomes a fresh entry instead.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!hit && ({1'b0, AW'(AW'(i) - rd_ptr)} < count) &&
          (tag_q[i] == push_dat[WIDTH-1:VW]) &&
          !(do_pop && (AW'(i) == rd_ptr))) begin
        hit     = 1'b1;
        hit_idx = AW'(i);
      end
    end
  end
  assign alloc = do_push && !hit;
`else
  assign hit     = 1'b0;
  assign hit_idx = '0;
  assign alloc   = do_push;
`endif

  always_ff @(posedge clk) begin
    if (alloc) begin
      tag_q[wr_ptr] <= push_dat[WIDTH-1:VW];
      val_q[wr_ptr] <= push_dat[VW-1:0];
    end
    if (do_push && hit) val_q[hit_idx] <= push_dat[VW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (alloc)  wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(alloc) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/pitch_slot_scheduler.sv
// Slot sequencer for the pitch datapath: key events applied in a 3-cycle frame gap, results realigned to pitch store.
// pitch_wr PIPE_LAT cycles after its slot; key_ready = FIFO not full. Option: PITCH_SCHED_COALESCE_EN.
module pitch_slot_scheduler
  import synth_sched_pkg::*;
#(
  parameter int VOICES     = 8,
  parameter int V_OSC      = 4,
  parameter int V_WIDTH    = 3,
  parameter int O_WIDTH    = 2,
  parameter int OE_WIDTH   = 1,
  parameter int E_WIDTH    = O_WIDTH + OE_WIDTH,
  parameter int PIPE_LAT   = 4,
  parameter int KEYQ_DEPTH = 4
) (
  input  logic                       sCLK_XVXOSC,
  input  logic                       reset_reg,
  input  logic                       run,
  input  logic                       key_req,
  input  logic [V_WIDTH-1:0]         key_voice,
  input  logic [7:0]                 key_val,
  output logic                       key_ready,
  output logic [V_WIDTH+E_WIDTH-1:0] xxxx,
  output logic                       frame_start,
  output logic [V_WIDTH-1:0]         cur_key_adr,
  output logic [7:0]                 cur_key_val,
  output logic                       note_on,
  input  logic [23:0]                osc_pitch_val,
  output logic                       pitch_wr,
  output logic [V_WIDTH+O_WIDTH-1:0] pitch_wr_adr,
  output logic [23:0]                pitch_wr_data
);

  localparam int S_W = V_WIDTH + E_WIDTH;
  localparam int K_W = V_WIDTH + 8;
  localparam logic [S_W-1:0] LAST_SLOT =
    {V_WIDTH'(VOICES - 1), O_WIDTH'(V_OSC - 1), {OE_WIDTH{1'b1}}};

  sched_state_t   state;
  logic           q_full, q_empty, q_push, q_pop, at_last;
  logic [K_W-1:0] q_head;
  logic [S_W:0]   pipe_q [PIPE_LAT];
  logic [S_W:0]   pipe_tail;

  assign at_last   = (state == ST_SLOT) && (xxxx == LAST_SLOT);
  assign q_push    = key_req && key_ready;
  assign q_pop     = at_last && !q_empty;
  assign key_ready = !q_full;

  key_event_fifo #(
    .DEPTH (KEYQ_DEPTH),
    .WIDTH (K_W),
    .TAG_W (V_WIDTH)
  ) u_keyq (
    .clk      (sCLK_XVXOSC),
    .rst      (reset_reg),
    .push_vld (q_push),
    .push_dat ({key_voice, key_val}),
    .pop_vld  (q_pop),
    .full     (q_full),
    .empty    (q_empty),
    .head_dat (q_head)
  );

  always_ff @(posedge sCLK_XVXOSC or posedge reset_reg) begin
    if (reset_reg) begin
      state       <= ST_IDLE;
      xxxx        <= '0;
      frame_start <= 1'b0;
      note_on     <= 1'b0;
      cur_key_adr <= '0;
      cur_key_val <= KEY_SILENT;
    end else begin
      frame_start <= 1'b0;
      note_on     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (run) begin
            state       <= ST_SLOT;
            frame_start <= 1'b1;
          end
        end
        ST_SLOT: begin
          if (!at_last) begin
            xxxx <= xxxx + S_W'(1);
          end else begin
            xxxx <= '0;
            // A pending key event always takes the gap, even when stopping.
            if (!q_empty) begin
              state       <= ST_GAP_SETUP;
              cur_key_adr <= q_head[K_W-1:8];
              cur_key_val <= q_head[7:0];
            end else if (run) begin
              frame_start <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_GAP_SETUP: begin
          state   <= ST_GAP_STROBE;
          note_on <= 1'b1;
        end
        ST_GAP_STROBE: state <= ST_GAP_HOLD;
        ST_GAP_HOLD: begin
          if (run) begin
            state       <= ST_SLOT;
            frame_start <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sCLK_XVXOSC or posedge reset_reg) begin
    if (reset_reg) begin
      for (int i = 0; i < PIPE_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= {state == ST_SLOT, xxxx};
      for (int i = 1; i < PIPE_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Only the last sub-slot of each osc carries the finished result.
  assign pipe_tail     = pipe_q[PIPE_LAT-1];
  assign pitch_wr      = pipe_tail[S_W] && (&pipe_tail[OE_WIDTH-1:0]);
  assign pitch_wr_adr  = pipe_tail[S_W-1:OE_WIDTH];
  assign pitch_wr_data = pitch_wr ? osc_pitch_val : '0;

endmodule
